norm_packer: RTL
================

Name: norm_packer

Overview:
- Receiver for the normalizer output stream.
- Each normalized vector arrives as COL consecutive serial beats per core stream (psum_norm_1, psum_norm_2, qualified by norm_valid), element 0 first.
- Reassembles both streams into COL-wide rows and buffers them in a small FIFO.
- Presents the rows on a valid/ready interface to the writeback/SRAM side.

Parameters:
- W_OUT, 16, width of one normalized element.
- COL, 8, elements per vector (power of two, >=2).
- DEPTH, 2, output row buffer entries (>=1).

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-low reset.
- norm_valid  input  1  beat qualifier from normalizer.
- psum_norm_1  input  W_OUT  core-1 normalized element.
- psum_norm_2  input  W_OUT  core-2 normalized element.
- m_valid  output  1  row available.
- m_ready  input  1  downstream accepts row.
- m_data_1  output  COL*W_OUT  core-1 row; element i at bits [i*W_OUT +: W_OUT].
- m_data_2  output  COL*W_OUT  core-2 row, same packing.
- level  output  $clog2(DEPTH+1)  rows currently buffered.
- overflow  output  1  sticky: a completed row was dropped.
- frame_err  output  1  sticky: norm_valid dropped mid-vector.

Behaviour:
- Reset (reset low, async assert, sync deassert): idx=0, assembly regs=0, FIFO empty, m_valid=0, m_data_1/2=0, level=0, overflow=0, frame_err=0.
- Beat counter idx is $clog2(COL) bits.
  - On norm_valid: asm_1[idx]<=psum_norm_1, asm_2[idx]<=psum_norm_2, idx<=idx+1 (wraps to 0 after COL-1).
- Row completion: norm_valid with idx==COL-1. The completed row (the current beat included) is pushed into the FIFO in the same cycle.
- Latency: last beat at edge t gives m_valid=1 and the row on m_data after edge t (visible in cycle t+1) if the FIFO was empty.
- No upstream backpressure (the normalizer cannot stall).
  - Push when full and no pop this cycle: row dropped, overflow<=1, FIFO unchanged.
  - Push when full with a pop this cycle (m_valid&&m_ready): push accepted, level unchanged, no overflow.
- Framing error: norm_valid=0 while idx!=0.
  - frame_err<=1 and idx<=0.
  - The partial row is discarded (never pushed).
  - The next norm_valid starts a fresh vector at element 0.
- Output handshake:
  - m_valid = (level!=0).
  - m_data_1/2 driven from the FIFO head register, stable while m_valid&&!m_ready.
  - Pop on m_valid&&m_ready; the next entry is presented the following cycle.
  - Empty FIFO with simultaneous push and pop cannot occur (m_valid=0).
- Back-to-back vectors: 2*COL continuous beats produce two rows; there is no idle beat between vectors.
- m_data holds its last value after the final pop (m_valid=0). It is not cleared.
- overflow and frame_err clear only on reset.
- Data is passed through unmodified: no arithmetic, no sign handling.

Decomposition:
- Shared package norm_pkg:
  - typedef row_t = logic [COL-1:0][W_OUT-1:0] (parameterized via package localparams matching normalizer defaults).
  - localparam IDX_W = $clog2(COL).
- Sub-module norm_row_fifo: synchronous FIFO of {row_t,row_t}, DEPTH entries.
  - Ports: push/pop, full/empty/level, registered head output.
  - Push-when-full-with-pop is allowed.
- norm_packer contains the beat counter, assembly registers, framing/overflow logic and handshake glue.

Test Plan:
- Single vector, m_ready=1:
  - Stimulus: 8 beats psum_norm_1=1..8, psum_norm_2=101..108.
  - Response: m_valid=1 one cycle after beat 8; m_data_1[0]=1, m_data_1[7]=8, m_data_2[7]=108; m_valid low next cycle; level back to 0.
- Overflow, m_ready=0, DEPTH=2:
  - Stimulus: three vectors (1..8, 11..18, 21..28).
  - Response: level=2 and overflow=1 after vector 3.
  - Then m_ready=1: rows 1..8 then 11..18 emitted, vector 21..28 never appears.
- Full with simultaneous pop:
  - Stimulus: FIFO full; m_ready=1 asserted in the cycle of the last beat of vector 3.
  - Response: overflow stays 0, level stays 2, vector 3 emitted after the other two.
- Framing error:
  - Stimulus: 3 beats (values 5,6,7), norm_valid low 1 cycle, then 8 beats 1..8.
  - Response: frame_err=1; exactly one row emitted, m_data_1 = 1..8.
- Async reset mid-vector:
  - Stimulus: drop reset after 4 beats.
  - Response: m_valid, level and flags go to 0 without a clock edge; after release, 8 beats 1..8 give one correct row.
- Back-to-back with backpressure pulses:
  - Stimulus: 16 continuous beats (1..16); m_ready toggling 1,0,1.
  - Response: rows 1..8 and 9..16 in order; m_data stable while m_valid&&!m_ready; no overflow.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared types and constants for the normalizer output packer.
//   W_OUT      : width of one normalized element
//   COL        : elements per vector (power of two, >= 2)
//   IDX_W      : width of the beat index within a vector
//   row_t      : one COL-wide row, element i at [i]
//   row_pair_t : the core-1 and core-2 rows that travel together
package norm_pkg;

  localparam int W_OUT = 16;
  localparam int COL   = 8;
  localparam int IDX_W = $clog2(COL);

  typedef logic [COL-1:0][W_OUT-1:0] row_t;

  typedef struct packed {
    row_t r1;
    row_t r2;
  } row_pair_t;

endpackage

// File: rtl/norm_row_fifo.sv
// Synchronous FIFO of row pairs with a registered head output.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_push       : write i_push_data (accepted when not full, or full with a pop)
//   i_push_data  : row pair to store
//   i_pop        : remove the head entry (ignored when empty)
//   o_full       : DEPTH entries stored
//   o_empty      : no entries stored
//   o_level      : entries currently stored
//   o_head       : head entry; keeps its last value once the FIFO drains
module norm_row_fifo
  import norm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  row_pair_t                  i_push_data,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output row_pair_t                  o_head
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  row_pair_t              r_mem [DEPTH];
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [LVL_W-1:0]       r_count;
  row_pair_t              r_head;

  logic                   w_do_push;
  logic                   w_do_pop;
  row_pair_t              w_head_next;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == LVL_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign o_head    = r_head;

  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: storage has no reset; only pointers, count and head define state.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Head register tracks the entry at the read pointer after this cycle's
  // push/pop. When the only stored entry is popped while a new one arrives,
  // the new entry is not in r_mem yet, so it is taken from i_push_data.
  always_comb begin
    // NOTE: default first so every path assigns, no latch is inferred.
    w_head_next = r_head;
    if (w_do_pop) begin
      if (r_count == LVL_W'(1)) begin
        if (w_do_push) w_head_next = i_push_data;
      end else begin
        w_head_next = r_mem[ptr_inc(r_rd_ptr)];
      end
    end else if (w_do_push && o_empty) begin
      w_head_next = i_push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      r_head <= w_head_next;
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/norm_packer.sv
// Receiver for the normalizer output stream. Collects COL serial beats per
// core into a row, buffers completed rows and offers them on valid/ready.
//   clk          : clock
//   reset        : asynchronous active-low reset
//   norm_valid   : beat qualifier (no backpressure toward the normalizer)
//   psum_norm_1  : core-1 element for this beat
//   psum_norm_2  : core-2 element for this beat
//   m_valid      : a row is available
//   m_ready      : downstream accepts the row
//   m_data_1/2   : core-1/core-2 row, element i at [i*W_OUT +: W_OUT]
//   level        : rows currently buffered
//   overflow     : sticky, a completed row was dropped because the buffer was full
//   frame_err    : sticky, norm_valid dropped in the middle of a vector
module norm_packer
  import norm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       norm_valid,
  input  logic [W_OUT-1:0]           psum_norm_1,
  input  logic [W_OUT-1:0]           psum_norm_2,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [COL*W_OUT-1:0]       m_data_1,
  output logic [COL*W_OUT-1:0]       m_data_2,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       frame_err
);

  logic [IDX_W-1:0] r_idx;
  row_t             r_asm_1;
  row_t             r_asm_2;
  logic             r_overflow;
  logic             r_frame_err;

  logic             w_last;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  row_pair_t        w_push_row;
  row_pair_t        w_head;

  assign w_last = norm_valid && (r_idx == IDX_W'(COL - 1));
  assign w_pop  = m_ready && !w_empty;
  assign w_drop = w_last && w_full && !w_pop;

  // The completing beat is pushed in the same cycle, so it bypasses the
  // assembly registers and is merged in here.
  always_comb begin
    w_push_row.r1          = r_asm_1;
    w_push_row.r2          = r_asm_2;
    w_push_row.r1[COL-1]   = psum_norm_1;
    w_push_row.r2[COL-1]   = psum_norm_2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx       <= '0;
      r_asm_1     <= '0;
      r_asm_2     <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (norm_valid) begin
        r_asm_1[r_idx] <= psum_norm_1;
        r_asm_2[r_idx] <= psum_norm_2;
        r_idx          <= r_idx + 1'b1;  // COL is a power of two: wraps naturally
      end else if (r_idx != '0) begin
        // Partial vector is abandoned; stale assembly contents are simply
        // overwritten by the next vector.
        r_frame_err <= 1'b1;
        r_idx       <= '0;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  norm_row_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .i_push      (w_last),
    .i_push_data (w_push_row),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (level),
    .o_head      (w_head)
  );

  assign m_valid   = !w_empty;
  assign m_data_1  = w_head.r1;
  assign m_data_2  = w_head.r2;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule
